// File: rtl/mc_cpu_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
package mc_cpu_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_TRAP    = 3'd6
    } seq_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/mc_perf_cnt.sv
// Free-running 64-bit cycle and retired-instruction counters for the sequencer.
module mc_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        cycle_en,
    input  logic        retire_en,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (cycle_en)  cycle_cnt   <= cycle_cnt + 64'd1;
            if (retire_en) instret_cnt <= instret_cnt + 64'd1;
        end
    end

endmodule

// File: rtl/mc_cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer owning PC and IR.
// Define MC_SEQ_PERF_CNT_EN to add the cycle/instret counter outputs.
//
// state      | meaning
// RESET      | held while rst is low, leaves on first edge after release
// FETCH      | imem request held until ack, IR captured on ack
// DECODE     | one cycle for regfile read
// EXECUTE    | redirect latched, misaligned redirect traps
// MEM        | dmem request held until ack
// WB         | regfile write, commit, PC update
// TRAP       | halted until reset
module mc_cpu_sequencer
    import mc_cpu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     inst_o,
    input  logic            dec_is_load_i,
    input  logic            dec_is_store_i,
    input  logic            dec_rd_we_i,
    input  logic            exe_branch_jump_i,
    input  logic [XLEN-1:0] exe_target_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    input  logic            dmem_ack_i,
    output logic            rf_we_o,
    output logic [XLEN-1:0] pc_o,
    output logic            commit_o,
    output logic [XLEN-1:0] commit_pc_o,
`ifdef MC_SEQ_PERF_CNT_EN
    output logic [63:0]     cycle_cnt_o,
    output logic [63:0]     instret_cnt_o,
`endif
    output logic            trap_o
);

    seq_state_e      state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            redir_taken;
    logic [XLEN-1:0] redir_target;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RESET;
        else      state <= state_nxt;
    end

    // Redirect is captured only in EXECUTE so later WB activity cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            inst         <= NOP_INST;
            redir_taken  <= 1'b0;
            redir_target <= '0;
        end else begin
            case (state)
                ST_FETCH: if (imem_ack_i) inst <= imem_rdata_i;
                ST_EXECUTE: begin
                    redir_taken  <= exe_branch_jump_i;
                    redir_target <= exe_target_i;
                end
                ST_WB: pc <= redir_taken ? redir_target : pc + XLEN'(PC_STEP);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        rf_we_o     = 1'b0;
        commit_o    = 1'b0;
        commit_pc_o = '0;
        trap_o      = 1'b0;
        case (state)
            ST_RESET:  state_nxt = ST_FETCH;
            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) state_nxt = ST_DECODE;
            end
            ST_DECODE: state_nxt = ST_EXECUTE;
            ST_EXECUTE: begin
                if (exe_branch_jump_i && (exe_target_i[1:0] != 2'b00))
                    state_nxt = ST_TRAP;
                else if (dec_is_load_i || dec_is_store_i)
                    state_nxt = ST_MEM;
                else
                    state_nxt = ST_WB;
            end
            ST_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = dec_is_store_i;
                if (dmem_ack_i) state_nxt = ST_WB;
            end
            ST_WB: begin
                rf_we_o     = dec_rd_we_i;
                commit_o    = 1'b1;
                commit_pc_o = pc;
                state_nxt   = ST_FETCH;
            end
            ST_TRAP:   trap_o = 1'b1;
            default:   state_nxt = ST_RESET;
        endcase
    end

    assign pc_o        = pc;
    assign imem_addr_o = pc;
    assign inst_o      = inst;

`ifdef MC_SEQ_PERF_CNT_EN
    mc_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .cycle_en    ((state != ST_RESET) && (state != ST_TRAP)),
        .retire_en   (commit_o),
        .cycle_cnt   (cycle_cnt_o),
        .instret_cnt (instret_cnt_o)
    );
`endif

endmodule

// File: tb/tb_mc_cpu_sequencer.sv
// Directed bench for mc_cpu_sequencer: reset, ALU, load/store, branch, reset abort, trap.
module tb_mc_cpu_sequencer;
    import mc_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic        dec_is_load_i, dec_is_store_i, dec_rd_we_i;
    logic        exe_branch_jump_i;
    logic [31:0] exe_target_i;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i;
    logic        rf_we_o;
    logic [31:0] pc_o;
    logic        commit_o;
    logic [31:0] commit_pc_o;
    logic        trap_o;
`ifdef MC_SEQ_PERF_CNT_EN
    logic [63:0] cycle_cnt_o, instret_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_cpu_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_ack_i        (imem_ack_i),
        .imem_rdata_i      (imem_rdata_i),
        .inst_o            (inst_o),
        .dec_is_load_i     (dec_is_load_i),
        .dec_is_store_i    (dec_is_store_i),
        .dec_rd_we_i       (dec_rd_we_i),
        .exe_branch_jump_i (exe_branch_jump_i),
        .exe_target_i      (exe_target_i),
        .dmem_req_o        (dmem_req_o),
        .dmem_we_o         (dmem_we_o),
        .dmem_ack_i        (dmem_ack_i),
        .rf_we_o           (rf_we_o),
        .pc_o              (pc_o),
        .commit_o          (commit_o),
        .commit_pc_o       (commit_pc_o),
`ifdef MC_SEQ_PERF_CNT_EN
        .cycle_cnt_o       (cycle_cnt_o),
        .instret_cnt_o     (instret_cnt_o),
`endif
        .trap_o            (trap_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic ld, input logic st, input logic we);
        dec_is_load_i  = ld;
        dec_is_store_i = st;
        dec_rd_we_i    = we;
    endtask

    initial begin
        rst = 1'b0;
        imem_ack_i = 1'b0; imem_rdata_i = '0;
        set_dec(1'b0, 1'b0, 1'b0);
        exe_branch_jump_i = 1'b0; exe_target_i = '0;
        dmem_ack_i = 1'b0;

        // reset values
        step(); step();
        chk("rst_pc", pc_o, 32'h8000_0000);
        chk("rst_iaddr", imem_addr_o, 32'h8000_0000);
        chk("rst_inst", inst_o, 32'h0000_0013);
        chk("rst_ireq", imem_req_o, 1'b0);
        chk("rst_dreq", dmem_req_o, 1'b0);
        chk("rst_commit", commit_o, 1'b0);
        chk("rst_cpc", commit_pc_o, 32'h0);
        chk("rst_trap", trap_o, 1'b0);
        rst = 1'b1;
        step();
        chk("fetch1_ireq", imem_req_o, 1'b1);

        // zero-wait ALU at 8000_0000
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0050_0093;
        step();                                    // DECODE
        imem_ack_i = 1'b0;
        chk("alu_inst", inst_o, 32'h0050_0093);
        chk("alu_ireq_drop", imem_req_o, 1'b0);
        set_dec(1'b0, 1'b0, 1'b1);
        step();                                    // EXECUTE
        chk("alu_exe_commit", commit_o, 1'b0);
        step();                                    // WB
        chk("alu_rfwe", rf_we_o, 1'b1);
        chk("alu_commit", commit_o, 1'b1);
        chk("alu_cpc", commit_pc_o, 32'h8000_0000);
        chk("alu_dreq", dmem_req_o, 1'b0);
        step();                                    // FETCH
        chk("alu_pc_next", pc_o, 32'h8000_0004);
        chk("alu_commit_drop", commit_o, 1'b0);

        // load with one imem wait and three dmem waits
        set_dec(1'b0, 1'b0, 1'b0);
        step();
        chk("ld_ireq_held", imem_req_o, 1'b1);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_a103;
        step();                                    // DECODE
        imem_ack_i = 1'b0;
        set_dec(1'b1, 1'b0, 1'b1);
        step();                                    // EXECUTE
        step();                                    // MEM 1
        chk("ld_dreq1", dmem_req_o, 1'b1);
        chk("ld_dwe", dmem_we_o, 1'b0);
        imem_ack_i = 1'b1; imem_rdata_i = 32'hdead_beef;
        step();                                    // MEM 2
        imem_ack_i = 1'b0;
        chk("ld_dreq2", dmem_req_o, 1'b1);
        step();                                    // MEM 3
        chk("ld_dreq3", dmem_req_o, 1'b1);
        chk("ld_no_commit", commit_o, 1'b0);
        step();                                    // MEM 4
        chk("ld_dreq4", dmem_req_o, 1'b1);
        dmem_ack_i = 1'b1;
        step();                                    // WB
        dmem_ack_i = 1'b0;
        chk("ld_dreq_drop", dmem_req_o, 1'b0);
        chk("ld_commit", commit_o, 1'b1);
        chk("ld_cpc", commit_pc_o, 32'h8000_0004);
        chk("ld_rfwe", rf_we_o, 1'b1);
        chk("ld_stray_ack", inst_o, 32'h0000_a103);
        step();
        chk("ld_pc_next", pc_o, 32'h8000_0008);

        // zero-wait store at 8000_0008
        set_dec(1'b0, 1'b0, 1'b0);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0020_a023;
        step();
        imem_ack_i = 1'b0;
        set_dec(1'b0, 1'b1, 1'b0);
        step();                                    // EXECUTE
        step();                                    // MEM
        chk("st_dreq", dmem_req_o, 1'b1);
        chk("st_dwe", dmem_we_o, 1'b1);
        dmem_ack_i = 1'b1;
        step();                                    // WB
        dmem_ack_i = 1'b0;
        chk("st_rfwe", rf_we_o, 1'b0);
        chk("st_commit", commit_o, 1'b1);
        chk("st_cpc", commit_pc_o, 32'h8000_0008);
        step();
        chk("st_pc_next", pc_o, 32'h8000_000c);

        // taken branch at 8000_000C to 8000_0010
        set_dec(1'b0, 1'b0, 1'b0);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0463;
        step();
        imem_ack_i = 1'b0;
        step();                                    // EXECUTE
        exe_branch_jump_i = 1'b1; exe_target_i = 32'h8000_0010;
        step();                                    // WB
        exe_branch_jump_i = 1'b0; exe_target_i = 32'hdead_beec;
        chk("br_no_mem", dmem_req_o, 1'b0);
        chk("br_commit", commit_o, 1'b1);
        chk("br_cpc", commit_pc_o, 32'h8000_000c);
        step();
        chk("br_pc", pc_o, 32'h8000_0010);
`ifdef MC_SEQ_PERF_CNT_EN
        chk("br_instret", instret_cnt_o, 64'd4);
`endif

        // ALU after branch: redirect must be cleared
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0010_8093;
        step();
        imem_ack_i = 1'b0;
        set_dec(1'b0, 1'b0, 1'b1);
        step(); step();                            // WB
        chk("alu2_cpc", commit_pc_o, 32'h8000_0010);
        step();
        chk("alu2_pc", pc_o, 32'h8000_0014);

        // reset pulsed during MEM wait
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0040_a183;
        step();
        imem_ack_i = 1'b0;
        set_dec(1'b1, 1'b0, 1'b1);
        step(); step();                            // MEM 1
        chk("abort_dreq", dmem_req_o, 1'b1);
        step();                                    // MEM 2
        rst = 1'b0;
        #1;
        chk("abort_dreq_drop", dmem_req_o, 1'b0);
        chk("abort_commit", commit_o, 1'b0);
        chk("abort_rfwe", rf_we_o, 1'b0);
        chk("abort_pc", pc_o, 32'h8000_0000);
        chk("abort_inst", inst_o, 32'h0000_0013);
        step();
        chk("abort_held_commit", commit_o, 1'b0);
        rst = 1'b1;
        set_dec(1'b0, 1'b0, 1'b0);
        step();
        chk("abort_fetch", imem_req_o, 1'b1);
        chk("abort_iaddr", imem_addr_o, 32'h8000_0000);
`ifdef MC_SEQ_PERF_CNT_EN
        chk("abort_instret", instret_cnt_o, 64'd0);
`endif

        // misaligned redirect traps
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_006f;
        step();
        imem_ack_i = 1'b0;
        set_dec(1'b0, 1'b0, 1'b1);
        step();                                    // EXECUTE
        exe_branch_jump_i = 1'b1; exe_target_i = 32'h8000_0002;
        chk("trap_not_yet", trap_o, 1'b0);
        step();                                    // TRAP
        exe_branch_jump_i = 1'b0;
        chk("trap_set", trap_o, 1'b1);
        chk("trap_commit", commit_o, 1'b0);
        chk("trap_rfwe", rf_we_o, 1'b0);
        chk("trap_ireq", imem_req_o, 1'b0);
        imem_ack_i = 1'b1; dmem_ack_i = 1'b1;
        step(); step(); step();
        imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
        chk("trap_sticky", trap_o, 1'b1);
        chk("trap_ireq_hold", imem_req_o, 1'b0);
        chk("trap_dreq_hold", dmem_req_o, 1'b0);
        chk("trap_commit_hold", commit_o, 1'b0);
        chk("trap_pc", pc_o, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
